// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the MAR/MDR memory interface: default widths, handshake
// FSM state encoding and memory command encoding.
package cpu_mem_pkg;

    localparam int unsigned MEM_DATA_W         = 32;
    localparam int unsigned MEM_ADDR_W         = 9;
    localparam int unsigned MEM_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } memState_t;

    // Value carried on memWe while memReq is high.
    typedef enum logic {
        MEM_CMD_RD = 1'b0,
        MEM_CMD_WR = 1'b1
    } memCmd_t;

endpackage

// File: rtl/mem_handshake_fsm.sv
// req/ack memory handshake FSM: sequencing, wait-state timeout, memReq/memWe/done/memErr.
// Optional timeout watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_handshake_fsm
    import cpu_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic clr,
    input  logic rdStart,
    input  logic wrStart,
    input  logic memAck,
    output logic memReq,
    output logic memWe,
    output logic busy,
    output logic done,
    output logic memErr,
    output logic rdCapture_c
);

    memState_t state;
    memState_t stateNext;
    logic      timeoutHit;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] waitCnt;
    logic             waiting;

    assign waiting    = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
    assign timeoutHit = waiting && !memAck && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside the wait states, so it is clear on every entry.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            waitCnt <= '0;
        end else if (!waiting) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + CNT_W'(1);
        end
    end

    // Sticky error, cleared only when a new transaction is accepted.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            memErr <= 1'b0;
        end else if ((state == ST_IDLE) && (rdStart || wrStart)) begin
            memErr <= 1'b0;
        end else if (timeoutHit) begin
            memErr <= 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign memErr     = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        rdCapture_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rdStart) begin
                    stateNext = ST_RD_WAIT;
                end else if (wrStart) begin
                    stateNext = ST_WR_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (memAck) begin
                    stateNext   = ST_DONE;
                    rdCapture_c = 1'b1;
                end else if (timeoutHit) begin
                    stateNext = ST_DONE;
                end
            end
            ST_WR_WAIT: begin
                if (memAck || timeoutHit) begin
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            memReq <= 1'b0;
            memWe  <= MEM_CMD_RD;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            memReq <= (stateNext == ST_RD_WAIT) || (stateNext == ST_WR_WAIT);
            memWe  <= (stateNext == ST_WR_WAIT) ? MEM_CMD_WR : MEM_CMD_RD;
            busy   <= (stateNext != ST_IDLE);
            done   <= (stateNext == ST_DONE);
        end
    end

endmodule

// File: rtl/mem_data_interface.sv
// MAR/MDR stage between the datapath bus and main memory, sequenced by mem_handshake_fsm.
// Define MEM_TIMEOUT_EN to enable the wait-state timeout and memErr flag.
module mem_data_interface
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DATA_W         = MEM_DATA_W,
    parameter int unsigned ADDR_W         = MEM_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] busMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              rdStart,
    input  logic              wrStart,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memAck,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic [DATA_W-1:0] mdrOut,
    output logic [ADDR_W-1:0] marOut,
    output logic              busy,
    output logic              done,
    output logic              memErr
);

    logic [ADDR_W-1:0] marReg;
    logic [DATA_W-1:0] mdrReg;
    logic              rdCapture_c;
    logic              idle;

    assign idle = !busy;

    mem_handshake_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) uFsm (
        .clk         (clk),
        .clr         (clr),
        .rdStart     (rdStart),
        .wrStart     (wrStart),
        .memAck      (memAck),
        .memReq      (memReq),
        .memWe       (memWe),
        .busy        (busy),
        .done        (done),
        .memErr      (memErr),
        .rdCapture_c (rdCapture_c)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            marReg <= '0;
        end else if (idle && MARin) begin
            marReg <= busMuxOut[ADDR_W-1:0];
        end
    end

    // Read capture only happens in RD_WAIT, bus load only in IDLE: never both.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mdrReg <= '0;
        end else if (rdCapture_c) begin
            mdrReg <= memRdata;
        end else if (idle && MDRin) begin
            mdrReg <= busMuxOut;
        end
    end

    assign memAddr  = marReg;
    assign marOut   = marReg;
    assign memWdata = mdrReg;
    assign mdrOut   = mdrReg;

endmodule
